// File: rtl/jt12_adpcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jt12_adpcm_pkg
//  Purpose  : Shared types and helpers for the JT12 ADPCM address sequencer.
//             The channel state struct is sized for the widest supported ROM
//             address (AW_MAX). Narrower builds leave the upper naddr bits at
//             zero and mask them with naddr_mask().
//  Revision : 1.0 - initial release
// ============================================================================
package jt12_adpcm_pkg;

  // Widest ROM byte address and block register width supported
  localparam int AW_MAX = 32;
  localparam int RW_MAX = 32;
  // Nibble address width: one bit more than the byte address
  localparam int NAW    = AW_MAX + 1;
  // Default widths, and the nibble offset width of one block for them
  localparam int DEF_AW    = 24;
  localparam int DEF_RW    = 16;
  localparam int DEF_BLK_W = DEF_AW - DEF_RW + 1;

  typedef struct packed {
    logic [NAW-1:0] naddr;  // nibble address; bit 0 selects the nibble
    logic           on;     // channel is playing
    logic           first;  // next nibble starts a section
  } ch_state_t;

  // Ones in the low aw+1 bits (the nibble address range in use)
  function automatic logic [NAW-1:0] naddr_mask(input int aw);
    return (NAW'(1) << (aw + 1)) - NAW'(1);
  endfunction

  // Nibble address of the first nibble of block 'blk'
  function automatic logic [NAW-1:0] block_base(input logic [RW_MAX-1:0] blk,
                                                input int aw, input int rw);
    return NAW'(blk) << (aw - rw + 1);
  endfunction

  // True when naddr is the last nibble of block 'blk'
  function automatic logic end_nibble(input logic [NAW-1:0] naddr,
                                      input logic [RW_MAX-1:0] blk,
                                      input int aw, input int rw);
    logic [NAW-1:0] tail;
    tail = (NAW'(1) << (aw - rw + 1)) - NAW'(1);
    return (naddr & naddr_mask(aw)) == (block_base(blk, aw, rw) | tail);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_adpcm_chreg.sv
`default_nettype none
// ============================================================================
//  Module   : jt12_adpcm_chreg
//  Purpose  : NCH-entry register file holding start/end blocks and playback
//             state. CPU writes and key events land on any clock. The visited
//             slot is updated through the read-modify-write port. A key event
//             on a channel overrides that channel's read-modify-write update,
//             and key-off beats key-on.
//  Revision : 1.0 - initial release
// ============================================================================
module jt12_adpcm_chreg
  import jt12_adpcm_pkg::*;
#(
  parameter int NCH = 6,
  parameter int AW  = 24,
  parameter int RW  = 16,
  parameter int CW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   wr_addr,
  input  logic [CW-1:0]   wr_ch,
  input  logic            wr_start,
  input  logic            wr_end,
  input  logic [NCH-1:0]  key_on,
  input  logic [NCH-1:0]  key_off,
  input  logic [CW-1:0]   rmw_ch,
  input  logic            rmw_we,
  input  ch_state_t       rmw_state,
  output ch_state_t       rd_state,
  output logic [RW-1:0]   rd_start,
  output logic [RW-1:0]   rd_end,
  output logic [NCH-1:0]  on_mask
);

  logic [RW-1:0] start_q [NCH];
  logic [RW-1:0] start_d [NCH];
  logic [RW-1:0] end_q   [NCH];
  logic [RW-1:0] end_d   [NCH];
  ch_state_t     st_q    [NCH];
  ch_state_t     st_d    [NCH];

  // Next state per channel: CPU writes, slot update, then key events on top
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      start_d[i] = start_q[i];
      end_d[i]   = end_q[i];
      st_d[i]    = st_q[i];
      if (wr_start && (wr_ch == CW'(i))) start_d[i] = wr_addr;
      if (wr_end   && (wr_ch == CW'(i))) end_d[i]   = wr_addr;
      if (rmw_we   && (rmw_ch == CW'(i))) st_d[i]   = rmw_state;
      if (key_off[i]) begin
        st_d[i].on = 1'b0;
      end else if (key_on[i]) begin
        st_d[i].naddr = block_base(RW_MAX'(start_q[i]), AW, RW);
        st_d[i].on    = 1'b1;
        st_d[i].first = 1'b1;
      end
    end
  end

  // Register file storage, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
        st_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        start_q[i] <= start_d[i];
        end_q[i]   <= end_d[i];
        st_q[i]    <= st_d[i];
      end
    end
  end

  assign rd_state = st_q[rmw_ch];
  assign rd_start = start_q[rmw_ch];
  assign rd_end   = end_q[rmw_ch];

  for (genvar g = 0; g < NCH; g++) begin : g_on
    assign on_mask[g] = st_q[g].on;
  end

endmodule
`default_nettype wire

// File: rtl/jt12_adpcm_acnt.sv
`default_nettype none
// ============================================================================
//  Module   : jt12_adpcm_acnt
//  Purpose  : ADPCM address sequencer. Visits one channel per cen and emits
//             the ROM address, nibble select and decoder restart for active
//             channels. Raises sticky end-of-sample flags.
//  Config   : JT12_ADPCM_LOOP_EN - when defined, loop_en makes a channel
//             reload its start block at the end instead of stopping.
//  Revision : 1.0 - initial release
// ============================================================================
module jt12_adpcm_acnt
  import jt12_adpcm_pkg::*;
#(
  parameter int NCH = 6,
  parameter int AW  = 24,
  parameter int RW  = 16,
  parameter int CW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic [RW-1:0]   wr_addr,
  input  logic [CW-1:0]   wr_ch,
  input  logic            wr_start,
  input  logic            wr_end,
  input  logic [NCH-1:0]  key_on,
  input  logic [NCH-1:0]  key_off,
  input  logic [NCH-1:0]  loop_en,
  input  logic [NCH-1:0]  clr_flags,
  output logic [CW-1:0]   slot,
  output logic [AW-1:0]   addr_out,
  output logic            sel,
  output logic            roe_n,
  output logic            clr,
  output logic [NCH-1:0]  busy,
  output logic [NCH-1:0]  flags
);

  // cnt is the channel being visited; slot names the channel whose outputs
  // are currently presented, one cen behind cnt
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  slot_q, slot_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           sel_q, sel_d;
  logic           roe_n_q, roe_n_d;
  logic           clr_q, clr_d;
  logic [NCH-1:0] flags_q, flags_d;
  logic [NCH-1:0] flag_set;

  ch_state_t      cur, nxt;
  logic [RW-1:0]  cur_start, cur_end;
  logic           key_ev, visit, end_hit, upd;

  jt12_adpcm_chreg #(.NCH(NCH), .AW(AW), .RW(RW), .CW(CW)) u_chreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_addr   (wr_addr),
    .wr_ch     (wr_ch),
    .wr_start  (wr_start),
    .wr_end    (wr_end),
    .key_on    (key_on),
    .key_off   (key_off),
    .rmw_ch    (cnt_q),
    .rmw_we    (upd),
    .rmw_state (nxt),
    .rd_state  (cur),
    .rd_start  (cur_start),
    .rd_end    (cur_end),
    .on_mask   (busy)
  );

`ifndef JT12_ADPCM_LOOP_EN
  logic unused_cfg;
  assign unused_cfg = ^{loop_en, cur_start};
`endif

  // Slot visit: read the current nibble, then advance, loop or stop
  always_comb begin
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    roe_n_d  = roe_n_q;
    clr_d    = clr_q;
    flag_set = '0;
    upd      = 1'b0;
    nxt      = cur;
    nxt.first = 1'b0;
    key_ev   = key_on[cnt_q] | key_off[cnt_q];
    visit    = cen && cur.on && !key_ev;
    end_hit  = end_nibble(cur.naddr, RW_MAX'(cur_end), AW, RW);
    if (cen) begin
      slot_d  = cnt_q;
      cnt_d   = (cnt_q == CW'(NCH - 1)) ? '0 : cnt_q + CW'(1);
      roe_n_d = 1'b1;
      clr_d   = 1'b0;
    end
    if (visit) begin
      upd     = 1'b1;
      addr_d  = cur.naddr[AW:1];
      sel_d   = cur.naddr[0];
      roe_n_d = 1'b0;
      clr_d   = cur.first;
      if (end_hit) begin
        flag_set[cnt_q] = 1'b1;
`ifdef JT12_ADPCM_LOOP_EN
        if (loop_en[cnt_q]) begin
          nxt.naddr = block_base(RW_MAX'(cur_start), AW, RW);
          nxt.first = 1'b1;
        end else begin
          nxt.on = 1'b0;
        end
`else
        nxt.on = 1'b0;
`endif
      end else begin
        nxt.naddr = (cur.naddr + NAW'(1)) & naddr_mask(AW);
      end
    end
    flags_d = (flags_q & ~clr_flags) | flag_set;
  end

  // Output and sequencing registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      slot_q  <= '0;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      roe_n_q <= 1'b1;
      clr_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      roe_n_q <= roe_n_d;
      clr_q   <= clr_d;
      flags_q <= flags_d;
    end
  end

  assign slot     = slot_q;
  assign addr_out = addr_q;
  assign sel      = sel_q;
  assign roe_n    = roe_n_q;
  assign clr      = clr_q;
  assign flags    = flags_q;

endmodule
`default_nettype wire

// File: doc/jt12_adpcm_acnt.md
# jt12_adpcm_acnt

Parametrised ADPCM address sequencer for the JT12 ADPCM path. It time-multiplexes `NCH` channels over a slot counter and holds per-channel start/end registers written by the CPU. Each active channel advances one nibble per visit, with an optional loop mode. It feeds ROM address, nibble select and decoder control to the ADPCM decoder, and raises per-channel end flags to the status register.

## Interface

Parameters:

- `NCH`, 6: channel count (2..16).
- `AW`, 24: ROM byte-address width.
- `RW`, 16: start/end register width. Block granularity is 2^(AW-RW) bytes. `AW > RW` is required.
- `CW`, `$clog2(NCH)`: channel index width (derived).

Ports:

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cen` in 1: slot-rate clock enable.
- `wr_addr` in RW: CPU start/end value.
- `wr_ch` in CW: target channel for a CPU write.
- `wr_start` in 1: one-clk strobe, load start register.
- `wr_end` in 1: one-clk strobe, load end register.
- `key_on` in NCH: one-clk per-channel key-on mask.
- `key_off` in NCH: one-clk per-channel key-off mask.
- `loop_en` in NCH: per-channel loop mode (level).
- `clr_flags` in NCH: per-channel flag clear (level).
- `slot` out CW: channel of the current output.
- `addr_out` out AW: ROM byte address.
- `sel` out 1: nibble select; 0 = high nibble first.
- `roe_n` out 1: ROM read enable, active-low.
- `clr` out 1: decoder restart; first nibble of a section.
- `busy` out NCH: channel playing.
- `flags` out NCH: sticky end-of-sample flags.

## Operation

Per-channel state:

- `start`: RW bits.
- `end`: RW bits.
- `naddr`: nibble address, AW+1 bits.
- `on`: playing.
- `first`: next nibble begins a section.

Slot sequencing:

- `slot` counts 0..NCH-1 and wraps to 0, advancing on every `cen`.

Each `cen` edge, for channel `c = slot`:

- If `on[c]` and there is no key event on `c` this clk:
  - Output `addr_out = naddr[AW:1]`, `sel = naddr[0]`, `roe_n = 0`, `clr = first[c]`.
  - Then clear `first[c]`.
  - If `naddr == {end, all ones}` (last nibble of the end block): with loop active, set `naddr = {start, 0}`, set `first = 1` and set `flags[c]`. Otherwise clear `on[c]` and set `flags[c]`.
  - Else `naddr` increments by 1, modulo 2^(AW+1).
- Otherwise output `roe_n = 1` and `clr = 0`. `addr_out` and `sel` hold their previous values.

Key events (act on any clk, not gated by `cen`):

- `key_on[c]` sets `naddr = {start, 0}`, `on = 1`, `first = 1`. A key-on while playing restarts the channel.
- `key_off[c]` clears `on`. If both bits are set for one channel, key-off wins.
- A key event on the visited channel in the same clk suppresses that visit (`roe_n = 1`).

CPU writes:

- They take effect immediately.
- A new `end` applies from the next visit.
- A new `start` applies at the next key-on or loop.

Flags:

- `flags <= (flags & ~clr_flags) | set`. Set wins over clear in the same clk.

Wrap and boundary behaviour:

- If `end < start`, `naddr` wraps through zero and stops at `end`.
- With `start == end`, one block (2^(AW-RW+1) nibbles) is played.

## Timing

- All outputs are registered. A slot's outputs are valid from the clk after its `cen` edge until the next `cen` edge.
- Key-on to first read: the channel's next slot visit, so 1..NCH `cen` periods.
- The final nibble is read on the visit that sets the flag. `busy[c]` falls on that same edge.
- Reset values:
  - outputs: `slot = 0`, `addr_out = 0`, `sel = 0`, `roe_n = 1`, `clr = 0`, `busy = 0`, `flags = 0`.
  - channel state: `start = 0`, `end = 0`, `naddr = 0`, `on = 0`, `first = 0`.
- Reset mid-playback stops all channels immediately. Nothing resumes after release.

## Configuration

- `JT12_ADPCM_LOOP_EN` defined: `loop_en` is honoured. At the end of the sample the channel reloads start, pulses `clr` on the next read, sets its flag and stays on.
- Not defined: `loop_en` is ignored and no loop logic is generated. Every channel stops at its end address.

## Structure

- Package `jt12_adpcm_pkg` holds:
  - the channel-state struct (`naddr`, `on`, `first`);
  - width localparams derived from `AW`/`RW`;
  - the end-nibble compare function.
- Sub-module `jt12_adpcm_chreg`: NCH-entry register file for start/end/state. It has a write port for CPU/key events and a read-modify-write port for the visited slot, with key-event priority resolved inside.

## Test plan

Use `NCH = 6`, `AW = 24`, `RW = 16`.

1. **One-block playback.** Program ch2 `start = end = 0x0010`, then key-on ch2. Expect 512 reads at slot 2: `addr_out` 0x001000..0x0010FF, `sel` alternating 0/1, `clr = 1` only on the first read. Then `busy[2] = 0` and `flags[2] = 1`.
2. **Loop mode.** Repeat scenario 1 with `JT12_ADPCM_LOOP_EN` defined and `loop_en[2] = 1`. Expect read 513 at 0x001000 with `clr = 1`, `flags[2] = 1`, and `busy[2]` still 1. Without the macro, expect the scenario 1 result.
3. **Key-off priority and restart.** Key-off on ch0 mid-sample gives `roe_n = 1` at slot 0 from the next visit. Simultaneous key-on and key-off on ch0 leaves `busy[0] = 0`. Key-on while playing restarts at start with `clr = 1`.
4. **Address wrap.** Program ch5 `start = 0xFFFF`, `end = 0x0000`. Expect `addr_out` to go 0xFFFFFF → 0x000000 and stop after 0x0000FF, low nibble.
5. **Flag set/clear collision.** Hold `clr_flags[1] = 1` in the clk where ch1 ends. Expect `flags[1] = 1`. Releasing and re-asserting the clear drops it to 0.
6. **Reset mid-playback.** Assert `rst_n` low with all channels on. Expect every output at its reset value immediately. After release, expect `roe_n = 1` in all slots until a new key-on.
